// File: rtl/cache_mem_arbiter_if.sv
// Bundle of client (icache, dcache, write buffer) and memory-bridge signals around the arbiter.
// master: arbiter side; slave: clients plus bridge.
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  logic              ic_rd_req;
  logic [ADDR_W-1:0] ic_rd_addr;
  logic              ic_rd_gnt;
  logic              ic_rd_valid;
  logic [LINE_W-1:0] ic_rd_data;

  logic              dc_rd_req;
  logic [ADDR_W-1:0] dc_rd_addr;
  logic              dc_rd_gnt;
  logic              dc_rd_valid;
  logic [LINE_W-1:0] dc_rd_data;

  logic              wb_wr_req;
  logic [ADDR_W-1:0] wb_wr_addr;
  logic [LINE_W-1:0] wb_wr_data;
  logic              wb_full;
  logic              wb_wr_gnt;
  logic              wb_wr_done;

  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_ready;
  logic              mem_rd_valid;
  logic [LINE_W-1:0] mem_rd_data;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [LINE_W-1:0] mem_wr_data;
  logic              mem_wr_ready;
  logic              mem_wr_done;

  modport master (
    input  ic_rd_req, ic_rd_addr, dc_rd_req, dc_rd_addr,
    input  wb_wr_req, wb_wr_addr, wb_wr_data, wb_full,
    input  mem_rd_ready, mem_rd_valid, mem_rd_data, mem_wr_ready, mem_wr_done,
    output ic_rd_gnt, ic_rd_valid, ic_rd_data, dc_rd_gnt, dc_rd_valid, dc_rd_data,
    output wb_wr_gnt, wb_wr_done,
    output mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data
  );

  modport slave (
    output ic_rd_req, ic_rd_addr, dc_rd_req, dc_rd_addr,
    output wb_wr_req, wb_wr_addr, wb_wr_data, wb_full,
    output mem_rd_ready, mem_rd_valid, mem_rd_data, mem_wr_ready, mem_wr_done,
    input  ic_rd_gnt, ic_rd_valid, ic_rd_data, dc_rd_gnt, dc_rd_valid, dc_rd_data,
    input  wb_wr_gnt, wb_wr_done,
    input  mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between icache refill, dcache refill and write-buffer drain.
// One transaction outstanding; reads round-robin, dirty writes forced ahead when needed.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned OFS_W        = 5,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_mem_arbiter_if.master  bus,
  output logic                 arb_busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StRdResp, StWrReq, StWrWait} state_e;

  state_e            state_q;
  logic              rr_q;           // 1: icache wins the next tie
  logic [CNT_W-1:0]  starve_q;
  logic              rd_owner_dc_q;
  logic [LINE_W-1:0] rd_buf_q;

  logic hazard, force_wr, any_rd, pick_dc;

  assign hazard   = bus.dc_rd_req &&
                    (bus.dc_rd_addr[ADDR_W-1:OFS_W] == bus.wb_wr_addr[ADDR_W-1:OFS_W]);
  assign force_wr = bus.wb_wr_req &&
                    (bus.wb_full || (starve_q == CNT_W'(STARVE_LIMIT)) || hazard);
  assign any_rd   = bus.ic_rd_req || bus.dc_rd_req;
  assign pick_dc  = bus.dc_rd_req && (!bus.ic_rd_req || !rr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      rr_q            <= 1'b0;
      starve_q        <= '0;
      rd_owner_dc_q   <= 1'b0;
      rd_buf_q        <= '0;
      arb_busy        <= 1'b0;
      bus.ic_rd_gnt   <= 1'b0;
      bus.ic_rd_valid <= 1'b0;
      bus.ic_rd_data  <= '0;
      bus.dc_rd_gnt   <= 1'b0;
      bus.dc_rd_valid <= 1'b0;
      bus.dc_rd_data  <= '0;
      bus.wb_wr_gnt   <= 1'b0;
      bus.wb_wr_done  <= 1'b0;
      bus.mem_rd_req  <= 1'b0;
      bus.mem_rd_addr <= '0;
      bus.mem_wr_req  <= 1'b0;
      bus.mem_wr_addr <= '0;
      bus.mem_wr_data <= '0;
    end else begin
      bus.ic_rd_gnt   <= 1'b0;
      bus.dc_rd_gnt   <= 1'b0;
      bus.wb_wr_gnt   <= 1'b0;
      bus.ic_rd_valid <= 1'b0;
      bus.dc_rd_valid <= 1'b0;
      bus.wb_wr_done  <= 1'b0;
      if (!bus.wb_wr_req) starve_q <= '0;

      case (state_q)
        StIdle: begin
          if (force_wr || (!any_rd && bus.wb_wr_req)) begin
            state_q         <= StWrReq;
            arb_busy        <= 1'b1;
            starve_q        <= '0;
            bus.wb_wr_gnt   <= 1'b1;
            bus.mem_wr_req  <= 1'b1;
            bus.mem_wr_addr <= {bus.wb_wr_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            bus.mem_wr_data <= bus.wb_wr_data;
          end else if (any_rd) begin
            state_q        <= StRdReq;
            arb_busy       <= 1'b1;
            rd_owner_dc_q  <= pick_dc;
            rr_q           <= pick_dc;
            bus.mem_rd_req <= 1'b1;
            if (pick_dc) begin
              bus.dc_rd_gnt   <= 1'b1;
              bus.mem_rd_addr <= {bus.dc_rd_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            end else begin
              bus.ic_rd_gnt   <= 1'b1;
              bus.mem_rd_addr <= {bus.ic_rd_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            end
            if (bus.wb_wr_req && (starve_q != CNT_W'(STARVE_LIMIT))) starve_q <= starve_q + 1'b1;
          end
        end
        StRdReq: begin
          if (bus.mem_rd_ready) begin
            bus.mem_rd_req <= 1'b0;
            // The bridge may return the line in the same cycle it accepts the request.
            if (bus.mem_rd_valid) begin
              rd_buf_q <= bus.mem_rd_data;
              state_q  <= StRdResp;
            end else begin
              state_q  <= StRdWait;
            end
          end
        end
        StRdWait: begin
          if (bus.mem_rd_valid) begin
            rd_buf_q <= bus.mem_rd_data;
            state_q  <= StRdResp;
          end
        end
        StRdResp: begin
          state_q  <= StIdle;
          arb_busy <= 1'b0;
          if (rd_owner_dc_q) begin
            bus.dc_rd_valid <= 1'b1;
            bus.dc_rd_data  <= rd_buf_q;
          end else begin
            bus.ic_rd_valid <= 1'b1;
            bus.ic_rd_data  <= rd_buf_q;
          end
        end
        StWrReq: begin
          if (bus.mem_wr_ready) begin
            bus.mem_wr_req <= 1'b0;
            if (bus.mem_wr_done) begin
              bus.wb_wr_done <= 1'b1;
              arb_busy       <= 1'b0;
              state_q        <= StIdle;
            end else begin
              state_q        <= StWrWait;
            end
          end
        end
        StWrWait: begin
          if (bus.mem_wr_done) begin
            bus.wb_wr_done <= 1'b1;
            arb_busy       <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: begin
          state_q  <= StIdle;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

  // Requesters must hold their address steady until granted.
  ic_addr_held: assert property (@(posedge clk) disable iff (reset)
    bus.ic_rd_req && !bus.ic_rd_gnt |=>
      bus.ic_rd_gnt || (bus.ic_rd_req && $stable(bus.ic_rd_addr)));
  dc_addr_held: assert property (@(posedge clk) disable iff (reset)
    bus.dc_rd_req && !bus.dc_rd_gnt |=>
      bus.dc_rd_gnt || (bus.dc_rd_req && $stable(bus.dc_rd_addr)));
  wb_addr_held: assert property (@(posedge clk) disable iff (reset)
    bus.wb_wr_req && !bus.wb_wr_gnt |=>
      bus.wb_wr_gnt || (bus.wb_wr_req && $stable(bus.wb_wr_addr)));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_cache_mem_arbiter;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned LINE_W       = 256;
  localparam int unsigned OFS_W        = 5;
  localparam int unsigned STARVE_LIMIT = 8;
  localparam int NONE = 0, IC = 1, DC = 2, WB = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic arb_busy;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  cache_mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .LINE_W      (LINE_W),
    .OFS_W       (OFS_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .arb_busy(arb_busy)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: which cache wins a tie, and reads granted while a write waits.
  bit m_rr_ic;
  int m_starve;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Small pool of lines so dcache/write-buffer line collisions happen often.
  function automatic logic [ADDR_W-1:0] rand_addr();
    return ADDR_W'(32'h0000_0200 + ($urandom_range(0, 3) * 32) + $urandom_range(0, 31));
  endfunction

  function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return (a / (2 ** OFS_W)) * (2 ** OFS_W);
  endfunction

  task automatic clear_inputs();
    bus.ic_rd_req    = 1'b0; bus.ic_rd_addr = '0;
    bus.dc_rd_req    = 1'b0; bus.dc_rd_addr = '0;
    bus.wb_wr_req    = 1'b0; bus.wb_wr_addr = '0; bus.wb_wr_data = '0; bus.wb_full = 1'b0;
    bus.mem_rd_ready = 1'b0; bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0;
    bus.mem_wr_ready = 1'b0; bus.mem_wr_done = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, arb_busy, 0);
    check_eq({tag, "_gnts"}, {bus.ic_rd_gnt, bus.dc_rd_gnt, bus.wb_wr_gnt}, 0);
    check_eq({tag, "_valids"}, {bus.ic_rd_valid, bus.dc_rd_valid, bus.wb_wr_done}, 0);
    check_eq({tag, "_mem_reqs"}, {bus.mem_rd_req, bus.mem_wr_req}, 0);
    check_eq({tag, "_mem_rd_addr"}, bus.mem_rd_addr, 0);
    check_eq({tag, "_mem_wr_addr"}, bus.mem_wr_addr, 0);
    check_eq({tag, "_mem_wr_data"}, bus.mem_wr_data, 0);
    check_eq({tag, "_ic_data"}, bus.ic_rd_data, 0);
    check_eq({tag, "_dc_data"}, bus.dc_rd_data, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    m_rr_ic  = 1'b0;
    m_starve = 0;
    check_idle("reset");
  endtask

  task automatic raise(input int who, input logic [ADDR_W-1:0] a);
    case (who)
      IC: begin bus.ic_rd_req = 1'b1; bus.ic_rd_addr = a; end
      DC: begin bus.dc_rd_req = 1'b1; bus.dc_rd_addr = a; end
      WB: begin bus.wb_wr_req = 1'b1; bus.wb_wr_addr = a; bus.wb_wr_data = rand_line(); end
      default: ;
    endcase
  endtask

  task automatic maybe_arrive();
    if (!bus.ic_rd_req && $urandom_range(0, 3) == 0) raise(IC, rand_addr());
    if (!bus.dc_rd_req && $urandom_range(0, 3) == 0) raise(DC, rand_addr());
    if (!bus.wb_wr_req && $urandom_range(0, 5) == 0) raise(WB, rand_addr());
    bus.wb_full = bus.wb_wr_req && ($urandom_range(0, 3) == 0);
  endtask

  // Who the arbitration rules pick from the requests currently presented.
  function automatic int predict();
    bit same_line;
    same_line = bus.dc_rd_req && ((bus.dc_rd_addr >> OFS_W) == (bus.wb_wr_addr >> OFS_W));
    if (bus.wb_wr_req && (bus.wb_full || m_starve >= STARVE_LIMIT || same_line)) return WB;
    if (bus.ic_rd_req && bus.dc_rd_req) return m_rr_ic ? IC : DC;
    if (bus.dc_rd_req) return DC;
    if (bus.ic_rd_req) return IC;
    if (bus.wb_wr_req) return WB;
    return NONE;
  endfunction

  // Run one arbitration decision and, if something is granted, the whole memory transaction.
  // Entry: arbiter idle this cycle. rdly: cycles before ready; vdly: cycles from ready to
  // valid/done (0 = same cycle).
  task automatic serve(input int rdly, input int vdly, input bit rnd, output int who);
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] d;
    bit                wb_waiting;
    who        = predict();
    wb_waiting = bus.wb_wr_req;
    a = (who == IC) ? bus.ic_rd_addr : (who == DC) ? bus.dc_rd_addr : bus.wb_wr_addr;
    d = bus.wb_wr_data;
    tick();
    check_eq("ic_rd_gnt", bus.ic_rd_gnt, who == IC);
    check_eq("dc_rd_gnt", bus.dc_rd_gnt, who == DC);
    check_eq("wb_wr_gnt", bus.wb_wr_gnt, who == WB);
    check_eq("busy_at_gnt", arb_busy, who != NONE);
    if (who == NONE) return;

    if (who == WB) begin
      m_starve = 0;
    end else begin
      m_rr_ic = (who == DC);
      if (wb_waiting && m_starve < STARVE_LIMIT) m_starve++;
    end
    case (who)
      IC: bus.ic_rd_req = 1'b0;
      DC: bus.dc_rd_req = 1'b0;
      default: begin bus.wb_wr_req = 1'b0; bus.wb_full = 1'b0; end
    endcase

    if (who == WB) begin
      check_eq("wr_req", bus.mem_wr_req, 1);
      check_eq("wr_addr", bus.mem_wr_addr, line_of(a));
      check_eq("wr_data", bus.mem_wr_data, d);
      for (int i = 0; i < rdly; i++) begin
        if (rnd) maybe_arrive();
        tick();
        check_eq("wr_req_held", bus.mem_wr_req, 1);
        check_eq("wr_addr_held", bus.mem_wr_addr, line_of(a));
        check_eq("wr_data_held", bus.mem_wr_data, d);
        check_eq("stray_gnt", {bus.ic_rd_gnt, bus.dc_rd_gnt, bus.wb_wr_gnt}, 0);
      end
      bus.mem_wr_ready = 1'b1;
      bus.mem_wr_done  = (vdly == 0);
      tick();
      bus.mem_wr_ready = 1'b0;
      bus.mem_wr_done  = 1'b0;
      for (int i = 0; i < vdly; i++) begin
        check_eq("wr_req_drop", bus.mem_wr_req, 0);
        check_eq("wr_done_early", bus.wb_wr_done, 0);
        if (rnd) maybe_arrive();
        if (i == vdly - 1) bus.mem_wr_done = 1'b1;
        tick();
        bus.mem_wr_done = 1'b0;
      end
      check_eq("wb_wr_done", bus.wb_wr_done, 1);
      check_eq("busy_after_wr", arb_busy, 0);
    end else begin
      check_eq("rd_req", bus.mem_rd_req, 1);
      check_eq("rd_addr", bus.mem_rd_addr, line_of(a));
      for (int i = 0; i < rdly; i++) begin
        if (rnd) maybe_arrive();
        bus.mem_rd_data = rand_line();
        tick();
        check_eq("rd_req_held", bus.mem_rd_req, 1);
        check_eq("rd_addr_held", bus.mem_rd_addr, line_of(a));
        check_eq("stray_gnt", {bus.ic_rd_gnt, bus.dc_rd_gnt, bus.wb_wr_gnt}, 0);
      end
      d = rand_line();
      bus.mem_rd_ready = 1'b1;
      bus.mem_rd_valid = (vdly == 0);
      bus.mem_rd_data  = (vdly == 0) ? d : rand_line();
      tick();
      bus.mem_rd_ready = 1'b0;
      bus.mem_rd_valid = 1'b0;
      for (int i = 0; i < vdly; i++) begin
        check_eq("rd_req_drop", bus.mem_rd_req, 0);
        check_eq("rd_valid_early", {bus.ic_rd_valid, bus.dc_rd_valid}, 0);
        if (rnd) maybe_arrive();
        bus.mem_rd_valid = (i == vdly - 1);
        bus.mem_rd_data  = (i == vdly - 1) ? d : rand_line();
        tick();
        bus.mem_rd_valid = 1'b0;
      end
      bus.mem_rd_data = rand_line();
      check_eq("rd_valid_early", {bus.ic_rd_valid, bus.dc_rd_valid}, 0);
      check_eq("busy_in_resp", arb_busy, 1);
      if (rnd) maybe_arrive();
      tick();
      check_eq("ic_rd_valid", bus.ic_rd_valid, who == IC);
      check_eq("dc_rd_valid", bus.dc_rd_valid, who == DC);
      if (who == IC) check_eq("ic_rd_data", bus.ic_rd_data, d);
      else           check_eq("dc_rd_data", bus.dc_rd_data, d);
      check_eq("busy_after_rd", arb_busy, 0);
    end
  endtask

  initial begin
    int who;
    int n_reads;
    clear_inputs();
    do_reset();

    // Single dcache refill, ready on the grant cycle and valid one cycle later.
    raise(DC, 32'h0000_0104);
    serve(0, 1, 1'b0, who);

    // Both caches requesting together, twice over: dcache, icache, dcache, icache.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      raise(IC, rand_addr());
      raise(DC, rand_addr());
      serve(1, 1, 1'b0, who);
      serve(0, 0, 1'b0, who);
    end

    // Same-line write and dcache read: write must go first.
    do_reset();
    raise(WB, 32'h0000_0200);
    raise(DC, 32'h0000_0204);
    serve(0, 2, 1'b0, who);
    serve(0, 1, 1'b0, who);

    // Waiting write with a steady stream of icache reads is forced after STARVE_LIMIT reads.
    do_reset();
    raise(WB, 32'h0000_0300);
    raise(IC, 32'h0000_1000);
    n_reads = 0;
    for (int i = 0; i < 20; i++) begin
      serve(0, 0, 1'b0, who);
      if (who != IC) break;
      n_reads++;
      raise(IC, ADDR_W'(32'h0000_1000 + i * 32));
    end
    check_eq("starve_reads", n_reads, STARVE_LIMIT);
    check_eq("starve_forced_wr", bus.wb_wr_done, 1);

    // Full write buffer beats pending reads; bridge stalls ready for 5 cycles.
    do_reset();
    raise(IC, 32'h0000_0400);
    raise(DC, 32'h0000_0500);
    raise(WB, 32'h0000_0600);
    bus.wb_full = 1'b1;
    serve(5, 1, 1'b0, who);
    serve(0, 0, 1'b0, who);
    serve(0, 0, 1'b0, who);

    // Reset while waiting for read data: everything clears, the late line is dropped.
    do_reset();
    raise(DC, 32'h0000_0140);
    tick();
    check_eq("t6_gnt", bus.dc_rd_gnt, 1);
    bus.dc_rd_req    = 1'b0;
    bus.mem_rd_ready = 1'b1;
    tick();
    bus.mem_rd_ready = 1'b0;
    check_eq("t6_busy_wait", arb_busy, 1);
    check_eq("t6_rd_req_drop", bus.mem_rd_req, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("t6");
    bus.mem_rd_valid = 1'b1;
    bus.mem_rd_data  = rand_line();
    tick();
    bus.mem_rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t6_no_valid", {bus.ic_rd_valid, bus.dc_rd_valid}, 0);
      check_eq("t6_idle", arb_busy, 0);
    end

    // Randomized traffic with arrivals during transactions and random bridge latencies.
    do_reset();
    for (int t = 0; t < 300; t++) begin
      maybe_arrive();
      serve($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, who);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
